// File: rtl/slot_seq_pkg.sv
// +--------------------------------------------------------------------+
// | slot_seq_pkg: slot status codes and sequencer state encoding. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

package slot_seq_pkg;

  localparam logic [1:0] c_status_empty = 2'd0;
  localparam logic [1:0] c_status_ready = 2'd1;
  localparam logic [1:0] c_status_done  = 2'd2;
  localparam logic [1:0] c_status_error = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4,
    S_NEXT  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/slot_seq_cmd_chan.sv
// +--------------------------------------------------------------------+
// | slot_seq_cmd_chan: one valid/ready command holder with sticky done.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module slot_seq_cmd_chan #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [SIZE_WIDTH-1:0] load_size,
  input  logic                  clear,
  input  logic                  ready,
  input  logic                  done,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [SIZE_WIDTH-1:0] size,
  output logic                  accepted,
  output logic                  done_flag
);

  logic r_acc;
  logic w_take;

  assign w_take   = valid & ready;
  // Counts the accepting cycle itself so a done in that cycle is not lost.
  assign accepted = r_acc | w_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= 1'b0;
      addr      <= '0;
      size      <= '0;
      r_acc     <= 1'b0;
      done_flag <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      addr      <= load_addr;
      size      <= load_size;
      r_acc     <= 1'b0;
      done_flag <= 1'b0;
    end else if (clear) begin
      r_acc     <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      if (w_take) begin
        valid <= 1'b0;
        r_acc <= 1'b1;
      end
      if (accepted && done) begin
        done_flag <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/slot_sequencer.sv
// +--------------------------------------------------------------------+
// | slot_sequencer: walks descriptor slots, issues MM2S/S2MM commands    |
// | for READY slots and writes status/profile back. Rev 1.0             |
// +--------------------------------------------------------------------+
`default_nettype none

module slot_sequencer
  import slot_seq_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int INPUT_IDX_WIDTH = 2,
  parameter int SRC_ADDR_WIDTH  = 32,
  parameter int SRC_SIZE_WIDTH  = 26,
  parameter int DST_ADDR_WIDTH  = 32,
  parameter int DST_SIZE_WIDTH  = 26,
  parameter int STATUS_WIDTH    = 2,
  parameter int PROFILE_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       walk_done,
  output logic [INPUT_IDX_WIDTH-1:0] rd_idx,
  input  logic [SRC_ADDR_WIDTH-1:0]  rd_src_addr,
  input  logic [SRC_SIZE_WIDTH-1:0]  rd_src_size,
  input  logic [DST_ADDR_WIDTH-1:0]  rd_des_addr,
  input  logic [DST_SIZE_WIDTH-1:0]  rd_des_size,
  input  logic [STATUS_WIDTH-1:0]    rd_status,
  output logic [INPUT_IDX_WIDTH-1:0] wr_idx,
  output logic [STATUS_WIDTH-1:0]    wr_status,
  output logic [PROFILE_WIDTH-1:0]   wr_profile,
  output logic                       set_status,
  output logic                       set_profile,
  output logic                       mm2s_valid,
  input  logic                       mm2s_ready,
  output logic [SRC_ADDR_WIDTH-1:0]  mm2s_addr,
  output logic [SRC_SIZE_WIDTH-1:0]  mm2s_size,
  input  logic                       mm2s_done,
  output logic                       s2mm_valid,
  input  logic                       s2mm_ready,
  output logic [DST_ADDR_WIDTH-1:0]  s2mm_addr,
  output logic [DST_SIZE_WIDTH-1:0]  s2mm_size,
  input  logic                       s2mm_done
);

  localparam logic [INPUT_IDX_WIDTH-1:0] c_last_idx = INPUT_IDX_WIDTH'(NUM_SLOTS - 1);

  state_t                   r_state;
  logic [PROFILE_WIDTH-1:0] r_cnt;
  logic [PROFILE_WIDTH-1:0] w_cnt_inc;
  logic                     w_slot_ready;
  logic                     w_size_zero;
  logic                     w_load;
  logic                     w_clear;
  logic                     w_m_acc;
  logic                     w_s_acc;
  logic                     w_m_done;
  logic                     w_s_done;
  logic                     w_both_done;

  assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + PROFILE_WIDTH'(1);
  assign w_slot_ready = (rd_status == STATUS_WIDTH'(c_status_ready));
  assign w_size_zero  = (rd_src_size == '0) || (rd_des_size == '0);
  assign w_load       = (r_state == S_FETCH) && w_slot_ready && !w_size_zero;
  assign w_both_done  = w_m_done && w_s_done;
  assign w_clear      = (r_state == S_WAIT) && w_both_done;

  slot_seq_cmd_chan #(
    .ADDR_WIDTH (SRC_ADDR_WIDTH),
    .SIZE_WIDTH (SRC_SIZE_WIDTH)
  ) u_mm2s (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_addr (rd_src_addr),
    .load_size (rd_src_size),
    .clear     (w_clear),
    .ready     (mm2s_ready),
    .done      (mm2s_done),
    .valid     (mm2s_valid),
    .addr      (mm2s_addr),
    .size      (mm2s_size),
    .accepted  (w_m_acc),
    .done_flag (w_m_done)
  );

  slot_seq_cmd_chan #(
    .ADDR_WIDTH (DST_ADDR_WIDTH),
    .SIZE_WIDTH (DST_SIZE_WIDTH)
  ) u_s2mm (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_addr (rd_des_addr),
    .load_size (rd_des_size),
    .clear     (w_clear),
    .ready     (s2mm_ready),
    .done      (s2mm_done),
    .valid     (s2mm_valid),
    .addr      (s2mm_addr),
    .size      (s2mm_size),
    .accepted  (w_s_acc),
    .done_flag (w_s_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      busy        <= 1'b0;
      walk_done   <= 1'b0;
      rd_idx      <= '0;
      wr_idx      <= '0;
      wr_status   <= '0;
      wr_profile  <= '0;
      set_status  <= 1'b0;
      set_profile <= 1'b0;
    end else begin
      walk_done   <= 1'b0;
      set_status  <= 1'b0;
      set_profile <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            rd_idx  <= '0;
            busy    <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!w_slot_ready) begin
            r_state <= S_NEXT;
          end else if (w_size_zero) begin
            wr_idx      <= rd_idx;
            wr_status   <= STATUS_WIDTH'(c_status_error);
            wr_profile  <= '0;
            set_status  <= 1'b1;
            set_profile <= 1'b1;
            r_state     <= S_WB;
          end else begin
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= w_cnt_inc;
          if (w_m_acc && w_s_acc) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          // Write-back strobes are registered, so they are raised on WB entry.
          if (w_both_done) begin
            wr_idx      <= rd_idx;
            wr_status   <= STATUS_WIDTH'(c_status_done);
            wr_profile  <= w_cnt_inc;
            set_status  <= 1'b1;
            set_profile <= 1'b1;
            r_state     <= S_WB;
          end
        end
        S_WB: begin
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (rd_idx == c_last_idx) begin
            walk_done <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            rd_idx  <= rd_idx + INPUT_IDX_WIDTH'(1);
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slot_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_slot_sequencer: bench with bank and DMA responder models.         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_slot_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        walk_done;
  logic [1:0]  rd_idx;
  logic [31:0] rd_src_addr;
  logic [25:0] rd_src_size;
  logic [31:0] rd_des_addr;
  logic [25:0] rd_des_size;
  logic [1:0]  rd_status;
  logic [1:0]  wr_idx;
  logic [1:0]  wr_status;
  logic [31:0] wr_profile;
  logic        set_status;
  logic        set_profile;
  logic        mm2s_valid;
  logic        mm2s_ready;
  logic [31:0] mm2s_addr;
  logic [25:0] mm2s_size;
  logic        mm2s_done;
  logic        s2mm_valid;
  logic        s2mm_ready;
  logic [31:0] s2mm_addr;
  logic [25:0] s2mm_size;
  logic        s2mm_done;

  slot_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .walk_done   (walk_done),
    .rd_idx      (rd_idx),
    .rd_src_addr (rd_src_addr),
    .rd_src_size (rd_src_size),
    .rd_des_addr (rd_des_addr),
    .rd_des_size (rd_des_size),
    .rd_status   (rd_status),
    .wr_idx      (wr_idx),
    .wr_status   (wr_status),
    .wr_profile  (wr_profile),
    .set_status  (set_status),
    .set_profile (set_profile),
    .mm2s_valid  (mm2s_valid),
    .mm2s_ready  (mm2s_ready),
    .mm2s_addr   (mm2s_addr),
    .mm2s_size   (mm2s_size),
    .mm2s_done   (mm2s_done),
    .s2mm_valid  (s2mm_valid),
    .s2mm_ready  (s2mm_ready),
    .s2mm_addr   (s2mm_addr),
    .s2mm_size   (s2mm_size),
    .s2mm_done   (s2mm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- descriptor bank model ----------------
  logic [31:0] b_src_addr [4];
  logic [25:0] b_src_size [4];
  logic [31:0] b_des_addr [4];
  logic [25:0] b_des_size [4];
  logic [7:0]  b_status;
  logic [7:0]  cfg_status;
  logic        cfg_load;

  assign rd_src_addr = b_src_addr[rd_idx];
  assign rd_src_size = b_src_size[rd_idx];
  assign rd_des_addr = b_des_addr[rd_idx];
  assign rd_des_size = b_des_size[rd_idx];
  assign rd_status   = b_status[2*rd_idx +: 2];

  always @(posedge clk) begin
    if (cfg_load) b_status <= cfg_status;
    else if (set_status) b_status[2*wr_idx +: 2] <= wr_status;
  end

  // ---------------- DMA responder model ----------------
  int m_rdy, s_rdy, m_k, s_k;
  bit early_s;
  int m_wait, s_wait, m_since, s_since;
  bit m_pend, s_pend;

  assign mm2s_ready = (m_wait >= m_rdy);
  assign s2mm_ready = (s_wait >= s_rdy);
  assign mm2s_done  = (m_k == 0) ? 1'b1 : (m_pend && m_since == m_k);
  assign s2mm_done  = ((s_k == 0) ? 1'b1 : (s_pend && s_since == s_k))
                      || (early_s && s2mm_valid && !s2mm_ready);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wait <= 0; s_wait <= 0; m_pend <= 0; s_pend <= 0; m_since <= 0; s_since <= 0;
    end else begin
      m_wait <= (mm2s_valid && !mm2s_ready) ? m_wait + 1 : 0;
      s_wait <= (s2mm_valid && !s2mm_ready) ? s_wait + 1 : 0;
      if (mm2s_valid && mm2s_ready) begin m_pend <= 1; m_since <= 1; end
      else if (m_pend) begin
        if (m_since == m_k) m_pend <= 0;
        m_since <= m_since + 1;
      end
      if (s2mm_valid && s2mm_ready) begin s_pend <= 1; s_since <= 1; end
      else if (s_pend) begin
        if (s_since == s_k) s_pend <= 0;
        s_since <= s_since + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { int idx; int st; int prof; } wb_t;
  typedef struct { logic [31:0] addr; logic [25:0] size; } cmd_t;
  wb_t  wb_q [$];
  cmd_t m_q  [$];
  cmd_t s_q  [$];

  always @(negedge clk) begin
    if (!reset) begin
      if (set_status || set_profile) begin
        chk("wb_strobes_paired", {set_status, set_profile}, 2'b11);
        chk("wb_expected", wb_q.size() != 0, 1'b1);
        if (wb_q.size() != 0) begin
          wb_t e;
          e = wb_q.pop_front();
          chk("wb_idx", wr_idx, e.idx);
          chk("wb_status", wr_status, e.st);
          chk("wb_profile", wr_profile, e.prof);
        end
      end
      if (mm2s_valid) begin
        chk("mm2s_cmd_expected", m_q.size() != 0, 1'b1);
        if (m_q.size() != 0) begin
          chk("mm2s_addr", mm2s_addr, m_q[0].addr);
          chk("mm2s_size", mm2s_size, m_q[0].size);
          if (mm2s_ready) void'(m_q.pop_front());
        end
      end
      if (s2mm_valid) begin
        chk("s2mm_cmd_expected", s_q.size() != 0, 1'b1);
        if (s_q.size() != 0) begin
          chk("s2mm_addr", s2mm_addr, s_q[0].addr);
          chk("s2mm_size", s2mm_size, s_q[0].size);
          if (s2mm_ready) void'(s_q.pop_front());
        end
      end
    end
  end

  // ---------------- vector table ----------------
  // st packs slot statuses {s3,s2,s1,s0}; zsrc/zdst name a slot with a zero size.
  // exp_len = posedges after the start-sampling edge until walk_done is seen:
  // skipped slot 2, zero-size slot 3, READY slot F+5 where F is the edge (from the
  // first ISSUE edge) at which the later done flag sets; profile = F+2.
  typedef struct {
    logic [7:0] st;
    int zsrc, zdst;
    int m_rdy, s_rdy, m_k, s_k;
    bit early_s;
    int exp_prof;
    int exp_len;
  } vec_t;

  vec_t vecs [6];

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      b_src_addr[i] = 32'h1000 + 32'(i) * 32'h100;
      b_des_addr[i] = 32'h2000 + 32'(i) * 32'h100;
      b_src_size[i] = (i == v.zsrc) ? 26'd0 : 26'(64 + i);
      b_des_size[i] = (i == v.zdst) ? 26'd0 : 26'(64 + i);
    end
    m_rdy = v.m_rdy; s_rdy = v.s_rdy; m_k = v.m_k; s_k = v.s_k; early_s = v.early_s;
    cfg_status = v.st;
    @(negedge clk); cfg_load = 1'b1;
    @(negedge clk); cfg_load = 1'b0;
  endtask

  task automatic push_expect(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      if (v.st[2*i +: 2] == 2'd1) begin
        if (i == v.zsrc || i == v.zdst) begin
          wb_q.push_back('{idx: i, st: 3, prof: 0});
        end else begin
          wb_q.push_back('{idx: i, st: 2, prof: v.exp_prof});
          m_q.push_back('{addr: b_src_addr[i], size: b_src_size[i]});
          s_q.push_back('{addr: b_des_addr[i], size: b_des_size[i]});
        end
      end
    end
  endtask

  task automatic run_walk(input int exp_len, input int extra_start_at);
    int cyc;
    int spurious;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    cyc = 0;
    while (!walk_done && cyc < 200) begin
      start = (cyc == extra_start_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("walk_len", cyc, exp_len);
    chk("busy_at_walk_done", busy, 1'b0);
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (walk_done || busy) spurious++;
    end
    chk("quiet_after_walk", spurious, 0);
    chk("wb_left", wb_q.size(), 0);
    chk("mm2s_left", m_q.size(), 0);
    chk("s2mm_left", s_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{st: 8'h01, zsrc: -1, zdst: -1, m_rdy: 0, s_rdy: 0, m_k: 0, s_k: 0,
                early_s: 0, exp_prof: 2, exp_len: 11};
    vecs[1] = '{st: 8'h01, zsrc: -1, zdst: -1, m_rdy: 5, s_rdy: 0, m_k: 0, s_k: 0,
                early_s: 0, exp_prof: 7, exp_len: 16};
    vecs[2] = '{st: 8'h10, zsrc: 2, zdst: -1, m_rdy: 0, s_rdy: 0, m_k: 0, s_k: 0,
                early_s: 0, exp_prof: 0, exp_len: 9};
    vecs[3] = '{st: 8'h04, zsrc: -1, zdst: -1, m_rdy: 0, s_rdy: 2, m_k: 1, s_k: 2,
                early_s: 1, exp_prof: 6, exp_len: 15};
    vecs[4] = '{st: 8'h55, zsrc: -1, zdst: -1, m_rdy: 0, s_rdy: 0, m_k: 0, s_k: 0,
                early_s: 0, exp_prof: 2, exp_len: 20};
    vecs[5] = '{st: 8'h76, zsrc: -1, zdst: 1, m_rdy: 0, s_rdy: 1, m_k: 0, s_k: 0,
                early_s: 0, exp_prof: 3, exp_len: 13};

    reset = 1'b1; start = 1'b0; cfg_load = 1'b0; cfg_status = 8'h00;
    m_rdy = 0; s_rdy = 0; m_k = 0; s_k = 0; early_s = 0;
    load_vec(vecs[0]);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_walk_done", walk_done, 1'b0);
    chk("rst_rd_idx", rd_idx, 2'd0);
    chk("rst_wr", {wr_idx, wr_status, wr_profile, set_status, set_profile}, '0);
    chk("rst_cmd", {mm2s_valid, s2mm_valid, mm2s_addr, mm2s_size, s2mm_addr, s2mm_size}, '0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      push_expect(vecs[v]);
      run_walk(vecs[v].exp_len, -1);
    end

    // start pulsed mid-walk must not restart or extend the walk
    load_vec(vecs[4]);
    push_expect(vecs[4]);
    run_walk(vecs[4].exp_len, 3);

    // reset while waiting for completions: no write-back, status kept
    load_vec('{st: 8'h01, zsrc: -1, zdst: -1, m_rdy: 0, s_rdy: 0, m_k: 6, s_k: 6,
               early_s: 0, exp_prof: 0, exp_len: 0});
    m_q.push_back('{addr: b_src_addr[0], size: b_src_size[0]});
    s_q.push_back('{addr: b_des_addr[0], size: b_des_size[0]});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_valids", {mm2s_valid, s2mm_valid}, 2'b00);
    chk("async_rst_cmd", {mm2s_addr, mm2s_size, s2mm_addr, s2mm_size}, '0);
    chk("async_rst_wr", {wr_idx, wr_status, wr_profile, set_status, set_profile}, '0);
    chk("async_rst_rd_idx", rd_idx, 2'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("slot_status_kept", b_status[1:0], 2'd1);
    chk("cmds_accepted_before_reset", m_q.size() + s_q.size(), 0);
    repeat (10) @(negedge clk);
    load_vec(vecs[0]);
    push_expect(vecs[0]);
    run_walk(vecs[0].exp_len, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
